// File: rtl/sht40_meas_ctrl.sv
// SHT40 measurement sequencer: launches a command/read through an external I2C
// master, captures the 6-byte answer, checks both CRC-8 words and retries.
module sht40_meas_ctrl #(
    parameter logic [6:0]  SENSOR_ADDR = 7'h44,
    parameter logic [15:0] RETRY_WAIT  = 16'd2000,
    parameter int          MAX_RETRY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Meas_Start,
    input  logic [7:0]  Meas_Cmd,
    input  logic [2:0]  Master_State_Out,
    input  logic [3:0]  Bytes_Received,
    input  logic [7:0]  Data_Received,
    output logic        Processor_Ready,
    output logic [6:0]  Peripheral_Address,
    output logic [7:0]  Command_Data_Frames,
    output logic        i2c_writes,
    output logic [3:0]  SHT_Reads,
    output logic        CRC_Error,
    output logic        Busy,
    output logic        Done,
    output logic        Meas_Error,
    output logic [15:0] Temp_Raw,
    output logic [15:0] Rh_Raw
);
    localparam logic [2:0] MS_PROC = 3'b000;
    localparam logic [2:0] MS_END  = 3'b110;

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_FINISH, S_WAIT, S_DONE, S_FAIL
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cmd, r_b0, r_b1, r_b3, r_b4, r_crc;
    logic [2:0]  r_byte_idx;
    logic [7:0]  r_attempt_cnt;
    logic [15:0] r_wait_cnt;
    logic [3:0]  r_br_q;
    logic        r_br_vld, r_bad, r_seen_end, r_crc_err;
    logic [15:0] r_temp, r_rh;

    logic        w_latch_cmd, w_start_attempt, w_attempt_inc, w_commit;
    logic        w_capture, w_crc_slot, w_crc_bad, w_good, w_wait_done;
    logic [7:0]  w_crc_seed, w_crc_next;

    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
        return c;
    endfunction

    // Any change of the master's byte counter is one new byte, including 15->0.
    assign w_capture   = (r_state == S_RUN) && r_br_vld && (Bytes_Received != r_br_q)
                         && (r_byte_idx != 3'd6);
    assign w_crc_slot  = (r_byte_idx == 3'd2) || (r_byte_idx == 3'd5);
    assign w_crc_seed  = ((r_byte_idx == 3'd0) || (r_byte_idx == 3'd3)) ? 8'hFF : r_crc;
    assign w_crc_next  = crc8_step(w_crc_seed, Data_Received);
    assign w_crc_bad   = w_capture && w_crc_slot && (Data_Received != r_crc);
    assign w_good      = (r_byte_idx == 3'd6) && !r_bad;
    assign w_wait_done = ({1'b0, r_wait_cnt} + 17'd1) >= {1'b0, RETRY_WAIT};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_latch_cmd     = 1'b0;
        w_start_attempt = 1'b0;
        w_attempt_inc   = 1'b0;
        w_commit        = 1'b0;
        Processor_Ready = 1'b0;
        Busy            = 1'b1;
        Done            = 1'b0;
        Meas_Error      = 1'b0;
        case (r_state)
            S_IDLE: begin
                Busy = 1'b0;
                if (Meas_Start) begin
                    w_latch_cmd     = 1'b1;
                    w_start_attempt = 1'b1;
                    w_state_nxt     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (Master_State_Out == MS_PROC) Processor_Ready = 1'b1;
                else                             w_state_nxt     = S_RUN;
            end
            S_RUN: begin
                if ((Master_State_Out == MS_PROC) && r_seen_end) w_state_nxt = S_FINISH;
            end
            S_FINISH: begin
                if (w_good) begin
                    w_commit    = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (r_attempt_cnt < 8'(MAX_RETRY)) begin
                    w_attempt_inc = 1'b1;
                    w_state_nxt   = S_WAIT;
                end else begin
                    w_state_nxt = S_FAIL;
                end
            end
            S_WAIT: begin
                if (w_wait_done) begin
                    w_start_attempt = 1'b1;
                    w_state_nxt     = S_LAUNCH;
                end
            end
            S_DONE: begin
                Done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_FAIL: begin
                Meas_Error  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd         <= 8'd0;
            r_b0          <= 8'd0;
            r_b1          <= 8'd0;
            r_b3          <= 8'd0;
            r_b4          <= 8'd0;
            r_crc         <= 8'd0;
            r_byte_idx    <= 3'd0;
            r_attempt_cnt <= 8'd0;
            r_wait_cnt    <= 16'd0;
            r_br_q        <= 4'd0;
            r_br_vld      <= 1'b0;
            r_bad         <= 1'b0;
            r_seen_end    <= 1'b0;
            r_crc_err     <= 1'b0;
            r_temp        <= 16'd0;
            r_rh          <= 16'd0;
        end else begin
            if (w_latch_cmd) begin
                r_cmd         <= Meas_Cmd;
                r_attempt_cnt <= 8'd0;
            end else if (w_attempt_inc) begin
                r_attempt_cnt <= r_attempt_cnt + 8'd1;
            end

            if (w_start_attempt) begin
                r_byte_idx <= 3'd0;
                r_bad      <= 1'b0;
                r_seen_end <= 1'b0;
            end else begin
                if ((r_state == S_RUN) && (Master_State_Out == MS_END)) r_seen_end <= 1'b1;
                if (w_capture) begin
                    r_byte_idx <= r_byte_idx + 3'd1;
                    case (r_byte_idx)
                        3'd0:    r_b0 <= Data_Received;
                        3'd1:    r_b1 <= Data_Received;
                        3'd3:    r_b3 <= Data_Received;
                        3'd4:    r_b4 <= Data_Received;
                        default: ;
                    endcase
                    if (!w_crc_slot) r_crc <= w_crc_next;
                    if (w_crc_bad)   r_bad <= 1'b1;
                end
            end

            r_crc_err  <= w_crc_bad;
            r_wait_cnt <= ((r_state == S_WAIT) && !w_wait_done) ? r_wait_cnt + 16'd1 : 16'd0;
            // Tracking starts on the first clock after reset so no stale difference is seen.
            r_br_q     <= Bytes_Received;
            r_br_vld   <= 1'b1;

            if (w_commit) begin
                r_temp <= {r_b0, r_b1};
                r_rh   <= {r_b3, r_b4};
            end
        end
    end

    assign Peripheral_Address  = SENSOR_ADDR;
    assign Command_Data_Frames = r_cmd;
    assign i2c_writes          = 1'b1;
    assign SHT_Reads           = 4'd5;
    assign CRC_Error           = r_crc_err;
    assign Temp_Raw            = r_temp;
    assign Rh_Raw              = r_rh;
endmodule

// File: doc/sht40_meas_ctrl.md
SHT40_MEAS_CTRL -- requirements
Module: sht40_meas_ctrl

Interface
REQ-001 The block SHALL use one clock and one asynchronous, active-high reset.
REQ-002 Parameter SENSOR_ADDR SHALL have default 7'h44: the sensor I2C address.
REQ-003 Parameter RETRY_WAIT SHALL have default 16'd2000: idle cycles between attempts.
REQ-004 Parameter MAX_RETRY SHALL have default 3: retries allowed after the first attempt.
REQ-005 clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 Meas_Start  in  1  one-cycle request to start a measurement; ignored unless Busy=0.
REQ-008 Meas_Cmd  in  8  SHT40 command byte, latched when Meas_Start is accepted.
REQ-009 Master_State_Out  in  3  I2C master state (000 processor, 110 end).
REQ-010 Bytes_Received  in  4  master's free-running received-byte count; wraps modulo 16.
REQ-011 Data_Received  in  8  last byte received by the master.
REQ-012 Processor_Ready  out  1  launch request to the master.
REQ-013 Peripheral_Address  out  7  SHALL equal SENSOR_ADDR.
REQ-014 Command_Data_Frames  out  8  latched command.
REQ-015 i2c_writes  out  1  SHALL be constant 1.
REQ-016 SHT_Reads  out  4  SHALL be constant 4'd5, meaning 6 bytes.
REQ-017 CRC_Error  out  1  one-cycle abort pulse to the master.
REQ-018 Busy, Done, Meas_Error  out  1 each  status outputs.
REQ-019 Temp_Raw, Rh_Raw  out  16 each  validated measurement words.

Function
REQ-020 The FSM SHALL have states IDLE, LAUNCH, RUN, FINISH, WAIT, DONE, FAIL.
REQ-021 IDLE: Busy=0; on Meas_Start the FSM SHALL latch Meas_Cmd, clear attempt_cnt and byte_idx, and go to LAUNCH.
REQ-022 LAUNCH: Processor_Ready SHALL be 1 while Master_State_Out=000; on the first cycle Master_State_Out!=000, Processor_Ready SHALL drop and the FSM SHALL go to RUN.
REQ-023 Byte capture: Bytes_Received differing from its registered copy SHALL capture Data_Received into byte slot byte_idx (0..5) and increment byte_idx; a wrap from 15 to 0 SHALL count as one byte.
REQ-024 Captures with byte_idx=6 SHALL be ignored; byte_idx SHALL saturate at 6.
REQ-025 CRC SHALL be CRC-8 with polynomial 0x31, init 0xFF, no final XOR, computed over slots {0,1} and {3,4}, and compared with slots 2 and 5 respectively.
REQ-026 A mismatch SHALL be flagged the cycle after its CRC byte is captured; CRC_Error SHALL pulse high for exactly 1 cycle and mark the attempt bad.
REQ-027 RUN→FINISH SHALL occur when Master_State_Out returns to 000 after passing through 110.
REQ-028 FINISH: an attempt SHALL be good only if byte_idx=6 and no CRC mismatch occurred.
REQ-029 On a good attempt, Temp_Raw SHALL be {slot0,slot1} and Rh_Raw SHALL be {slot3,slot4}; both SHALL update only here, and the FSM SHALL go to DONE.
REQ-030 On a bad attempt (NACK, short read, or CRC): if attempt_cnt<MAX_RETRY, attempt_cnt SHALL increment and the FSM SHALL go to WAIT; otherwise it SHALL go to FAIL.
REQ-031 WAIT SHALL count RETRY_WAIT cycles, then clear byte_idx and go to LAUNCH.
REQ-032 DONE SHALL pulse Done for 1 cycle, then return to IDLE.
REQ-033 FAIL SHALL pulse Meas_Error for 1 cycle, then return to IDLE.
REQ-034 Busy SHALL be 1 in every state except IDLE.
REQ-035 Meas_Start during Busy=1 SHALL have no effect.
REQ-036 A CRC_Error pulse SHALL NOT be generated outside RUN.

Reset
REQ-037 While rst=1, the FSM SHALL be in IDLE.
REQ-038 While rst=1, Processor_Ready, CRC_Error, Busy, Done, and Meas_Error SHALL be 0.
REQ-039 While rst=1, Temp_Raw=0, Rh_Raw=0, Command_Data_Frames=0, and all counters SHALL be 0.
REQ-040 The registered copy of Bytes_Received SHALL load the live input on the first clock after reset release, so that no spurious capture occurs.
REQ-041 Reset asserted mid-transaction SHALL abort immediately; the master is not driven further.

Verification
REQ-042 Meas_Cmd=0xFD and the master model returns 0xBE,0xEF,0x92,0x66,0x66,0x93 → Temp_Raw=0xBEEF, Rh_Raw=0x6666, Done pulses once, and CRC_Error stays 0.
REQ-043 Byte 2 is corrupted to 0x00 → CRC_Error pulses 1 cycle after byte 2, and the run retries after RETRY_WAIT cycles.
REQ-044 The sensor NACKs on all 4 attempts → exactly 4 Processor_Ready launches occur, then Meas_Error pulses and Temp_Raw holds its prior value.
REQ-045 Bytes_Received starts at 14 → a 6-byte read through the wrap is captured correctly.
REQ-046 Meas_Start is asserted during RUN → it is ignored, and Command_Data_Frames is unchanged.
REQ-047 rst is pulsed mid-RUN → all outputs are 0 next cycle, and a subsequent Meas_Start completes normally.
